// File: rtl/count_fifo_arbiter.sv
// count_fifo_arbiter: merges two single-cycle counter-data pulses into one FIFO write stream.
// Each channel has a one-deep holding register; a round-robin arbiter drains them through an
// IDLE -> WRITE -> GAP sequence so the downstream full flag has a cycle to settle between writes.
module count_fifo_arbiter #(
    parameter bit TAG_EN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [63:0] req0_data,
    input  logic [63:0] req1_data,
    input  logic        fifo_full,
    output logic [63:0] fifo_writedata,
    output logic        fifo_write,
    input  logic        clr_drops,
    output logic [15:0] drop_cnt0,
    output logic [15:0] drop_cnt1,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle = 2'd0, StWrite = 2'd1, StGap = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        hold_v0_q, hold_v1_q;
    logic [63:0] hold_d0_q, hold_d1_q;
    logic        last_grant_q;
    logic        grant_v, grant_idx, grant0, grant1;
    logic [63:0] grant_sel, grant_word;
    logic        take0, take1, drop0, drop1;

    // Next-state and round-robin grant; fifo_full only matters while idle.
    always_comb begin
        state_d   = state_q;
        grant_v   = 1'b0;
        grant_idx = 1'b0;
        case (state_q)
            StIdle: begin
                if ((hold_v0_q || hold_v1_q) && !fifo_full) begin
                    grant_v   = 1'b1;
                    grant_idx = (hold_v0_q && hold_v1_q) ? ~last_grant_q : hold_v1_q;
                    state_d   = StWrite;
                end
            end
            StWrite: state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grant qualification, request capture/drop decisions and the outgoing word.
    always_comb begin
        grant0    = grant_v & ~grant_idx;
        grant1    = grant_v & grant_idx;
        // A grant in the same cycle frees the slot, so a new pulse refills it instead of dropping.
        take0     = req0_valid & enable & (~hold_v0_q | grant0);
        take1     = req1_valid & enable & (~hold_v1_q | grant1);
        drop0     = req0_valid & enable & hold_v0_q & ~grant0;
        drop1     = req1_valid & enable & hold_v1_q & ~grant1;
        grant_sel = grant_idx ? hold_d1_q : hold_d0_q;
        grant_word = TAG_EN ? {grant_idx, grant_sel[62:0]} : grant_sel;
    end

    // FSM state, registered write strobe, output word and arbitration pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            fifo_write     <= 1'b0;
            fifo_writedata <= 64'd0;
            last_grant_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            fifo_write <= (state_d == StWrite);
            if (grant_v) begin
                fifo_writedata <= grant_word;
                last_grant_q   <= grant_idx;
            end
        end
    end

    // Per-channel holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v0_q <= 1'b0;
            hold_v1_q <= 1'b0;
            hold_d0_q <= 64'd0;
            hold_d1_q <= 64'd0;
        end else begin
            if (take0) begin
                hold_v0_q <= 1'b1;
                hold_d0_q <= req0_data;
            end else if (grant0) begin
                hold_v0_q <= 1'b0;
            end
            if (take1) begin
                hold_v1_q <= 1'b1;
                hold_d1_q <= req1_data;
            end else if (grant1) begin
                hold_v1_q <= 1'b0;
            end
        end
    end

    // Saturating drop counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt0 <= 16'd0;
            drop_cnt1 <= 16'd0;
        end else if (clr_drops) begin
            drop_cnt0 <= 16'd0;
            drop_cnt1 <= 16'd0;
        end else begin
            if (drop0 && (drop_cnt0 != 16'hFFFF)) drop_cnt0 <= drop_cnt0 + 16'd1;
            if (drop1 && (drop_cnt1 != 16'hFFFF)) drop_cnt1 <= drop_cnt1 + 16'd1;
        end
    end

    // Busy while sequencing a write or while anything is waiting.
    always_comb begin
        busy = (state_q != StIdle) | hold_v0_q | hold_v1_q;
    end

endmodule

// File: tb/tb_count_fifo_arbiter.sv
// Bench for count_fifo_arbiter: untagged and tagged instances share stimulus; a slot-level
// reference model feeds expected words into scoreboards drained by a negedge monitor.
module tb_count_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reset, enable, req0_valid, req1_valid, fifo_full, clr_drops;
    logic [63:0] req0_data, req1_data;
    logic [63:0] wd, wd_t;
    logic        wr, wr_t, bsy, bsy_t;
    logic [15:0] dc0, dc1, dc0_t, dc1_t;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    count_fifo_arbiter #(.TAG_EN(1'b0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .fifo_full(fifo_full), .fifo_writedata(wd), .fifo_write(wr),
        .clr_drops(clr_drops), .drop_cnt0(dc0), .drop_cnt1(dc1), .busy(bsy)
    );

    count_fifo_arbiter #(.TAG_EN(1'b1)) u_dut_tag (
        .clk(clk), .reset(reset), .enable(enable),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .fifo_full(fifo_full), .fifo_writedata(wd_t), .fifo_write(wr_t),
        .clr_drops(clr_drops), .drop_cnt0(dc0_t), .drop_cnt1(dc1_t), .busy(bsy_t)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one slot per channel, writer unavailable for 2 edges after each grant.
    bit [1:0]    m_hold;
    logic [63:0] m_data [2];
    int          m_cool, m_last, g;
    int          m_drop [2];
    logic [63:0] m_word, m_word_t;
    logic [63:0] q[$], q_t[$];
    bit   [1:0]  v;
    logic [63:0] d [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hold = 2'b00; m_cool = 0; m_last = 1;
            m_drop[0] = 0; m_drop[1] = 0;
            m_word = 64'd0; m_word_t = 64'd0;
            q.delete(); q_t.delete();
        end else begin
            v = {req1_valid, req0_valid};
            d[0] = req0_data; d[1] = req1_data;
            if (m_cool > 0) begin
                m_cool--;
            end else if (m_hold != 2'b00 && !fifo_full) begin
                if (m_hold == 2'b11) g = (m_last == 0) ? 1 : 0;
                else g = m_hold[0] ? 0 : 1;
                m_hold[g] = 1'b0;
                m_last = g;
                m_cool = 2;
                m_word = m_data[g];
                m_word_t = {g[0], m_data[g][62:0]};
                q.push_back(m_word);
                q_t.push_back(m_word_t);
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (v[ch] && enable) begin
                    if (m_hold[ch]) begin
                        if (m_drop[ch] < 65535) m_drop[ch]++;
                    end else begin
                        m_hold[ch] = 1'b1;
                        m_data[ch] = d[ch];
                    end
                end
            end
            if (clr_drops) begin
                m_drop[0] = 0; m_drop[1] = 0;
            end
        end
    end

    // Monitor: compare every settled cycle; pop the scoreboard whenever a write is presented.
    always @(negedge clk) begin
        if (!reset) begin
            check("fifo_write", wr, m_cool == 2);
            check("fifo_write_tag", wr_t, m_cool == 2);
            check("busy", bsy, (m_cool != 0) || (m_hold != 2'b00));
            check("busy_tag", bsy_t, (m_cool != 0) || (m_hold != 2'b00));
            check("writedata_hold", wd, m_word);
            check("writedata_hold_tag", wd_t, m_word_t);
            check("drop_cnt0", dc0, m_drop[0]);
            check("drop_cnt1", dc1, m_drop[1]);
            check("drop_cnt0_tag", dc0_t, m_drop[0]);
            check("drop_cnt1_tag", dc1_t, m_drop[1]);
            if (wr) begin
                if (q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_write: got %h expected none", wd);
                end else check("scoreboard_word", wd, q.pop_front());
            end
            if (wr_t) begin
                if (q_t.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_write_tag: got %h expected none", wd_t);
                end else check("scoreboard_word_tag", wd_t, q_t.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        enable = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 64'd0; req1_data = 64'd0; fifo_full = 1'b0; clr_drops = 1'b0;
    endtask

    // Leaves the caller at a negedge with reset just released.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        idle_inputs();
        reset = 1'b1;
        #25;
        check("reset_write", wr, 1'b0);
        check("reset_data", wd, 64'd0);
        check("reset_busy", bsy, 1'b0);
        check("reset_drop0", dc0, 16'd0);
        check("reset_drop1", dc1, 16'd0);

        // Single request latency.
        do_reset();
        req0_valid = 1'b1; req0_data = 64'h1234;
        @(negedge clk); req0_valid = 1'b0;
        check("t1_c1_write", wr, 1'b0);
        check("t1_c1_busy", bsy, 1'b1);
        @(negedge clk);
        check("t1_c2_write", wr, 1'b1);
        check("t1_c2_data", wd, 64'h1234);
        @(negedge clk);
        check("t1_c3_write", wr, 1'b0);
        @(negedge clk);
        check("t1_c4_busy", bsy, 1'b0);

        // Simultaneous requests: ch0 first after reset, tag replaces bit 63.
        do_reset();
        req0_valid = 1'b1; req0_data = 64'hFFFF_0000_0000_000A;
        req1_valid = 1'b1; req1_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("t2_a_write", wr, 1'b1);
        check("t2_a_data", wd, 64'hFFFF_0000_0000_000A);
        check("t2_a_tag", wd_t, 64'h7FFF_0000_0000_000A);
        repeat (3) @(negedge clk);
        check("t2_b_write", wr, 1'b1);
        check("t2_b_data", wd, 64'h0123_4567_89AB_CDEF);
        check("t2_b_tag", wd_t, 64'h8123_4567_89AB_CDEF);

        // Backpressure: first held, two dropped, one write after release.
        do_reset();
        fifo_full = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_data = 64'd100 + 64'(i);
            @(negedge clk); req0_valid = 1'b0;
            if (wr) seen++;
            @(negedge clk);
            if (wr) seen++;
        end
        check("t3_drop0", dc0, 16'd2);
        check("t3_no_write", seen, 0);
        fifo_full = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr) begin
                seen++;
                check("t3_data", wd, 64'd100);
            end
        end
        check("t3_one_write", seen, 1);

        // Refill on grant: pulse in the granting cycle is captured, not dropped.
        do_reset();
        req0_valid = 1'b1; req0_data = 64'h11;
        @(negedge clk); req0_data = 64'h22;
        @(negedge clk); req0_valid = 1'b0;
        check("t4_first", wd, 64'h11);
        check("t4_first_write", wr, 1'b1);
        repeat (3) @(negedge clk);
        check("t4_second_write", wr, 1'b1);
        check("t4_second", wd, 64'h22);
        check("t4_no_drop", dc0, 16'd0);

        // Saturation, then clear beating a same-cycle drop.
        do_reset();
        fifo_full = 1'b1;
        req1_valid = 1'b1; req1_data = 64'h77;
        repeat (65541) @(negedge clk);
        req1_valid = 1'b0;
        check("t5_saturated", dc1, 16'hFFFF);
        req1_valid = 1'b1; clr_drops = 1'b1;
        @(negedge clk); req1_valid = 1'b0; clr_drops = 1'b0;
        check("t5_cleared", dc1, 16'd0);
        fifo_full = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset in the middle of a write.
        do_reset();
        req0_valid = 1'b1; req0_data = 64'h5555;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk);
        check("t6_pre_write", wr, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t6_write_dropped", wr, 1'b0);
        check("t6_data_reset", wd, 64'd0);
        check("t6_busy_reset", bsy, 1'b0);
        check("t6_drop0_reset", dc0, 16'd0);
        @(negedge clk); reset = 1'b0;
        req0_valid = 1'b1; req0_data = 64'h6666;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk);
        check("t6_after_write", wr, 1'b1);
        check("t6_after_data", wd, 64'h6666);
        repeat (3) @(negedge clk);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            req0_valid = ($urandom_range(0, 9) < 4);
            req1_valid = ($urandom_range(0, 9) < 4);
            req0_data  = {$urandom, $urandom};
            req1_data  = {$urandom, $urandom};
            fifo_full  = ($urandom_range(0, 3) == 0);
            clr_drops  = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        idle_inputs();
        repeat (12) @(negedge clk);
        check("drain_scoreboard", q.size(), 0);
        check("drain_scoreboard_tag", q_t.size(), 0);
        check("drain_idle", bsy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
